// File: rtl/pipelined_loop_controller.sv
// pipelined_loop_controller
//   Sequences one pipelined loop. A start pulse latches the trip count N and
//   launches N iterations, one every II clocks. The controller then waits DEPTH
//   clocks for the last iteration to leave the loop body and pulses done.
//   The loop-nest sequencer drives start/trip_count and receives done. The loop
//   body datapath receives issue/iter_idx.
//
//   Handshake: start is taken on any clock edge where ready=1, which means the
//   state is IDLE. A start while busy is dropped: it is neither latched nor
//   queued. ready is high in the done cycle, so loops can run back to back.
//
//   Optional feature macro: LOOP_STALL_EN adds a stall input. While stall is
//   high in ISSUE or DRAIN, every counter, iter_idx and the state hold, and
//   issue stays 0. Each stalled clock defers the next issue or done by one clock.
//   Stall has no effect in IDLE.
//
//   Outputs are registers, or decodes of the state register. No input reaches
//   an output combinationally.
module pipelined_loop_controller #(
    parameter int II    = 1,
    parameter int DEPTH = 3,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] trip_count,
`ifdef LOOP_STALL_EN
    input  logic         stall,
`endif
    output logic         ready,
    output logic         busy,
    output logic         issue,
    output logic [W-1:0] iter_idx,
    output logic         done,
    output logic [1:0]   dbg_state
);

    localparam int IIW = $clog2(II + 1);
    localparam int DW  = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t         state;
    logic [W-1:0]   n_lat;
    logic [IIW-1:0] ii_cnt;
    logic [DW-1:0]  dr_cnt;
    logic           hold;

`ifdef LOOP_STALL_EN
    assign hold = stall;
`else
    assign hold = 1'b0;
`endif

    // Sequencing FSM: latches N, paces issues by II, counts the drain, pulses done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            n_lat    <= '0;
            iter_idx <= '0;
            ii_cnt   <= '0;
            dr_cnt   <= '0;
            issue    <= 1'b0;
            done     <= 1'b0;
        end else begin
            issue <= 1'b0;
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n_lat <= trip_count;
                        if (trip_count == '0) begin
                            // An empty loop completes on the next cycle with no issue.
                            done <= 1'b1;
                        end else begin
                            issue    <= 1'b1;
                            iter_idx <= '0;
                            ii_cnt   <= '0;
                            dr_cnt   <= '0;
                            // A one-iteration loop issues its last iteration right away.
                            state    <= (trip_count == W'(1)) ? S_DRAIN : S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (!hold) begin
                        if (ii_cnt == IIW'(II - 1)) begin
                            issue    <= 1'b1;
                            iter_idx <= iter_idx + W'(1);
                            ii_cnt   <= '0;
                            // n_lat is at least 2 here, so n_lat-1 cannot wrap.
                            if (iter_idx + W'(1) == n_lat - W'(1)) begin
                                state  <= S_DRAIN;
                                dr_cnt <= '0;
                            end
                        end else begin
                            ii_cnt <= ii_cnt + IIW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (!hold) begin
                        if (dr_cnt == DW'(DEPTH - 1)) begin
                            done   <= 1'b1;
                            dr_cnt <= '0;
                            state  <= S_IDLE;
                        end else begin
                            dr_cnt <= dr_cnt + DW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Status flags decoded from the state register only
    always_comb begin
        ready     = (state == S_IDLE);
        busy      = (state != S_IDLE);
        dbg_state = state;
    end

endmodule

// File: tb/tb_pipelined_loop_controller.sv
// tb_pipelined_loop_controller
//   Drives several controller instances that differ in II/DEPTH from one
//   shared clock and reset. Each started loop schedules its expected issue and
//   done cycles into a per-instance queue. A negedge monitor pops and compares
//   them cycle by cycle, together with busy/ready and the held iter_idx.
//   The stall instance exists only when LOOP_STALL_EN is defined.
module tb_pipelined_loop_controller;

  localparam int W = 8;
`ifdef LOOP_STALL_EN
  localparam int NI = 4;
`else
  localparam int NI = 3;
`endif

  function automatic int ii_of(input int g);
    case (g)
      0: return 1;
      1: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int dep_of(input int g);
    case (g)
      0: return 3;
      1: return 2;
      2: return 1;
      default: return 2;
    endcase
  endfunction

  typedef struct {
    int           cyc;
    bit           is_done;
    logic [W-1:0] idx;
  } ev_t;

  typedef struct {
    int           inst;
    logic [W-1:0] n;
    int           lat;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic         start_v [NI];
  logic [W-1:0] trip_v  [NI];
  logic         ready_v [NI];
  logic         busy_v  [NI];
  logic         issue_v [NI];
  logic         done_v  [NI];
  logic [W-1:0] idx_v   [NI];
  logic [1:0]   dbg_v   [NI];
`ifdef LOOP_STALL_EN
  logic         stall_v [NI];
`endif

  for (genvar g = 0; g < NI; g++) begin : g_dut
    pipelined_loop_controller #(
      .II(ii_of(g)),
      .DEPTH(dep_of(g)),
      .W(W)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .start(start_v[g]),
      .trip_count(trip_v[g]),
`ifdef LOOP_STALL_EN
      .stall(stall_v[g]),
`endif
      .ready(ready_v[g]),
      .busy(busy_v[g]),
      .issue(issue_v[g]),
      .iter_idx(idx_v[g]),
      .done(done_v[g]),
      .dbg_state(dbg_v[g])
    );
  end

  // ---------------- scoreboard ----------------
  ev_t          exp_q [NI][$];
  logic [W-1:0] last_idx [NI];
  int           bfrom [NI];
  int           bto [NI];
  int           n_checks = 0;
  int           n_errors = 0;

  task automatic chk(input string nm, input int i, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d cyc %0d: got %0h expected %0h", nm, i, cyc, got, exp);
    end
  endtask

  ev_t          mon_ev;
  bit           e_iss;
  bit           e_done;
  bit           e_busy;
  logic [W-1:0] e_idx;

  // Compare every instance against its schedule once per cycle.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NI; i++) begin
        e_iss  = 1'b0;
        e_done = 1'b0;
        e_idx  = last_idx[i];
        while (exp_q[i].size() > 0 && exp_q[i][0].cyc <= cyc) begin
          mon_ev = exp_q[i].pop_front();
          if (mon_ev.is_done) e_done = 1'b1;
          else begin
            e_iss = 1'b1;
            e_idx = mon_ev.idx;
          end
        end
        last_idx[i] = e_idx;
        e_busy = (cyc >= bfrom[i]) && (cyc < bto[i]);
        chk("issue", i, W'(issue_v[i]), W'(e_iss));
        chk("done", i, W'(done_v[i]), W'(e_done));
        chk("iter_idx", i, idx_v[i], e_idx);
        chk("busy", i, W'(busy_v[i]), W'(e_busy));
        chk("ready", i, W'(ready_v[i]), W'(!e_busy));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int c);
    repeat (c) @(negedge clk);
  endtask

  // Call just after a negedge. The start is sampled at the end of this cycle.
  task automatic start_loop(input int i, input logic [W-1:0] n, input int lat);
    int t;
    t = cyc;
    start_v[i] = 1'b1;
    trip_v[i]  = n;
    for (int k = 0; k < int'(n); k++)
      exp_q[i].push_back('{cyc: t + 1 + k * ii_of(i), is_done: 1'b0, idx: W'(k)});
    exp_q[i].push_back('{cyc: t + lat, is_done: 1'b1, idx: '0});
    bfrom[i] = t + 1;
    bto[i]   = t + lat;
    @(negedge clk);
    start_v[i] = 1'b0;
    trip_v[i]  = W'($urandom);
  endtask

  // Start pulse that is expected to be ignored because the instance is busy.
  task automatic poke(input int i, input logic [W-1:0] n);
    start_v[i] = 1'b1;
    trip_v[i]  = n;
    @(negedge clk);
    start_v[i] = 1'b0;
  endtask

  vec_t vecs [8];

  initial begin
    for (int i = 0; i < NI; i++) begin
      start_v[i] = 1'b0;
      trip_v[i]  = '0;
      last_idx[i] = '0;
      bfrom[i] = 0;
      bto[i]   = 0;
`ifdef LOOP_STALL_EN
      stall_v[i] = 1'b0;
`endif
    end
    // Expected done latency measured from the start cycle.
    vecs[0] = '{inst: 0, n: 8'd4,   lat: 7};    // II=1 DEPTH=3
    vecs[1] = '{inst: 1, n: 8'd3,   lat: 9};    // II=3 DEPTH=2
    vecs[2] = '{inst: 0, n: 8'd0,   lat: 1};    // empty loop
    vecs[3] = '{inst: 2, n: 8'd2,   lat: 4};    // II=2 DEPTH=1
    vecs[4] = '{inst: 1, n: 8'd1,   lat: 3};    // single iteration
    vecs[5] = '{inst: 2, n: 8'd5,   lat: 10};
    vecs[6] = '{inst: 0, n: 8'd255, lat: 258};  // maximum trip count, last idx 254
    vecs[7] = '{inst: 1, n: 8'd0,   lat: 1};

    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("rst_ready", i, W'(ready_v[i]), W'(1));
      chk("rst_busy", i, W'(busy_v[i]), W'(0));
      chk("rst_issue", i, W'(issue_v[i]), W'(0));
      chk("rst_done", i, W'(done_v[i]), W'(0));
      chk("rst_idx", i, idx_v[i], W'(0));
    end
    rst = 1'b0;
    idle(2);

    // Table-driven loops
    for (int v = 0; v < 8; v++) begin
      start_loop(vecs[v].inst, vecs[v].n, vecs[v].lat);
      idle(vecs[v].lat + 2);
    end

    // Random trip counts on random instances
    for (int r = 0; r < 6; r++) begin
      int i;
      int n;
      int lat;
      i = $urandom_range(0, 2);
      n = $urandom_range(0, 6);
      lat = (n == 0) ? 1 : 1 + (n - 1) * ii_of(i) + dep_of(i);
      start_loop(i, W'(n), lat);
      idle(lat + $urandom_range(0, 3));
    end

    // Start while busy is ignored; a start in the done cycle is accepted
    start_loop(2, 8'd2, 4);   // returns at t+1
    idle(1);                  // t+2
    poke(2, 8'd7);            // dropped; returns at t+3
    idle(1);                  // t+4 = done cycle
    start_loop(2, 8'd1, 2);
    idle(4);

    // Back-to-back on II=1
    start_loop(0, 8'd2, 5);   // returns at t+1
    idle(4);                  // t+5 = done cycle
    start_loop(0, 8'd3, 6);
    idle(8);

    // Asynchronous reset mid-loop aborts without a done pulse
    start_loop(0, 8'd5, 8);   // returns at t+1
    idle(2);                  // t+3
    #2 rst = 1'b1;
    #1;
    chk("arst_issue", 0, W'(issue_v[0]), W'(0));
    chk("arst_done", 0, W'(done_v[0]), W'(0));
    chk("arst_busy", 0, W'(busy_v[0]), W'(0));
    chk("arst_ready", 0, W'(ready_v[0]), W'(1));
    chk("arst_idx", 0, idx_v[0], W'(0));
    for (int i = 0; i < NI; i++) begin
      exp_q[i].delete();
      last_idx[i] = '0;
      bfrom[i] = 0;
      bto[i]   = 0;
    end
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    start_loop(0, 8'd4, 7);
    idle(9);

`ifdef LOOP_STALL_EN
    // Stall during ISSUE defers the second issue by two clocks
    begin
      int t;
      t = cyc;
      start_v[3] = 1'b1;
      trip_v[3]  = 8'd3;
      exp_q[3].push_back('{cyc: t + 1, is_done: 1'b0, idx: 8'd0});
      exp_q[3].push_back('{cyc: t + 5, is_done: 1'b0, idx: 8'd1});
      exp_q[3].push_back('{cyc: t + 7, is_done: 1'b0, idx: 8'd2});
      exp_q[3].push_back('{cyc: t + 9, is_done: 1'b1, idx: 8'd0});
      bfrom[3] = t + 1;
      bto[3]   = t + 9;
      @(negedge clk);
      start_v[3] = 1'b0;
      @(negedge clk);
      stall_v[3] = 1'b1;
      idle(2);
      stall_v[3] = 1'b0;
      idle(8);
    end
    // Stall in IDLE does not block a start
    begin
      int t;
      t = cyc;
      stall_v[3] = 1'b1;
      start_v[3] = 1'b1;
      trip_v[3]  = 8'd1;
      exp_q[3].push_back('{cyc: t + 1, is_done: 1'b0, idx: 8'd0});
      exp_q[3].push_back('{cyc: t + 3, is_done: 1'b1, idx: 8'd0});
      bfrom[3] = t + 1;
      bto[3]   = t + 3;
      @(negedge clk);
      start_v[3] = 1'b0;
      stall_v[3] = 1'b0;
      idle(5);
    end
`endif

    // Every scheduled event must have been consumed
    for (int i = 0; i < NI; i++)
      chk("leftover_events", i, W'(exp_q[i].size()), W'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
